// File: rtl/writeback_unit.sv
// Register-file write port arbiter: merges single-cycle ALU results with
// multi-cycle memory loads, formatting load data before write-back.
module writeback_unit #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clk_enable,
   input  logic              alu_valid,
   input  logic [REG_AW-1:0] alu_rd,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              load_issue,
   input  logic [REG_AW-1:0] load_rd,
   input  logic [2:0]        load_type,
   input  logic [1:0]        load_offset,
   input  logic [DATA_W-1:0] load_old_rt,
   input  logic [DATA_W-1:0] mem_readdata,
   input  logic              mem_waitrequest,
   output logic [REG_AW-1:0] write_reg_rd,
   output logic              reg_write_enable,
   output logic [DATA_W-1:0] reg_write_data,
   output logic              stall,
   output logic              busy_valid,
   output logic [REG_AW-1:0] busy_rd
);

   localparam logic [0:0] IDLE     = 1'b0;
   localparam logic [0:0] WAIT_MEM = 1'b1;

   localparam logic [2:0] LB  = 3'd0;
   localparam logic [2:0] LBU = 3'd1;
   localparam logic [2:0] LH  = 3'd2;
   localparam logic [2:0] LHU = 3'd3;
   localparam logic [2:0] LWL = 3'd5;
   localparam logic [2:0] LWR = 3'd6;

   logic [0:0]        r_state;
   logic [REG_AW-1:0] r_ld_rd;
   logic [2:0]        r_ld_type;
   logic [1:0]        r_ld_off;
   logic [DATA_W-1:0] r_ld_old;
   logic [REG_AW-1:0] r_wr_rd;
   logic              r_wr_en;
   logic [DATA_W-1:0] r_wr_data;

   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [DATA_W-1:0] w_fmt_data;

   always_comb begin
      w_byte = mem_readdata[7:0];
      case (r_ld_off)
         2'd0: w_byte = mem_readdata[7:0];
         2'd1: w_byte = mem_readdata[15:8];
         2'd2: w_byte = mem_readdata[23:16];
         2'd3: w_byte = mem_readdata[31:24];
         default: w_byte = mem_readdata[7:0];
      endcase
   end

   // Halfword selection uses only offset bit 1; misaligned bit 0 is ignored.
   assign w_half = r_ld_off[1] ? mem_readdata[31:16] : mem_readdata[15:0];

   always_comb begin
      w_fmt_data = mem_readdata;
      case (r_ld_type)
         LB:  w_fmt_data = {{24{w_byte[7]}}, w_byte};
         LBU: w_fmt_data = {24'd0, w_byte};
         LH:  w_fmt_data = {{16{w_half[15]}}, w_half};
         LHU: w_fmt_data = {16'd0, w_half};
         LWL: begin
            case (r_ld_off)
               2'd0: w_fmt_data = {mem_readdata[7:0],  r_ld_old[23:0]};
               2'd1: w_fmt_data = {mem_readdata[15:0], r_ld_old[15:0]};
               2'd2: w_fmt_data = {mem_readdata[23:0], r_ld_old[7:0]};
               default: w_fmt_data = mem_readdata;
            endcase
         end
         LWR: begin
            case (r_ld_off)
               2'd1: w_fmt_data = {r_ld_old[31:24], mem_readdata[31:8]};
               2'd2: w_fmt_data = {r_ld_old[31:16], mem_readdata[31:16]};
               2'd3: w_fmt_data = {r_ld_old[31:8],  mem_readdata[31:24]};
               default: w_fmt_data = mem_readdata;
            endcase
         end
         default: w_fmt_data = mem_readdata;
      endcase
   end

   // ALU and load capture may both happen in IDLE; ALU input is dropped while a load waits.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_ld_rd   <= '0;
         r_ld_type <= '0;
         r_ld_off  <= '0;
         r_ld_old  <= '0;
         r_wr_rd   <= '0;
         r_wr_en   <= 1'b0;
         r_wr_data <= '0;
      end else if (clk_enable) begin
         r_wr_en <= 1'b0;
         if (r_state == IDLE) begin
            if (alu_valid) begin
               r_wr_rd   <= alu_rd;
               r_wr_data <= alu_data;
               r_wr_en   <= (alu_rd != '0);
            end
            if (load_issue) begin
               r_ld_rd   <= load_rd;
               r_ld_type <= load_type;
               r_ld_off  <= load_offset;
               r_ld_old  <= load_old_rt;
               r_state   <= WAIT_MEM;
            end
         end else if (!mem_waitrequest) begin
            r_wr_rd   <= r_ld_rd;
            r_wr_data <= w_fmt_data;
            r_wr_en   <= (r_ld_rd != '0);
            r_state   <= IDLE;
         end
      end
   end

   assign write_reg_rd     = r_wr_rd;
   assign reg_write_enable = r_wr_en;
   assign reg_write_data   = r_wr_data;
   assign stall            = (r_state == WAIT_MEM);
   assign busy_valid       = stall;
   assign busy_rd          = r_ld_rd;

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_writeback_unit;

   logic        clk;
   logic        reset;
   logic        clk_enable;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        load_issue;
   logic [4:0]  load_rd;
   logic [2:0]  load_type;
   logic [1:0]  load_offset;
   logic [31:0] load_old_rt;
   logic [31:0] mem_readdata;
   logic        mem_waitrequest;
   logic [4:0]  write_reg_rd;
   logic        reg_write_enable;
   logic [31:0] reg_write_data;
   logic        stall;
   logic        busy_valid;
   logic [4:0]  busy_rd;

   int testsRun = 0;
   int testsFailed = 0;
   bit checkEn = 0;

   writeback_unit #(.DATA_W(32), .REG_AW(5)) dut (
      .clk(clk), .reset(reset), .clk_enable(clk_enable),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .load_issue(load_issue), .load_rd(load_rd), .load_type(load_type),
      .load_offset(load_offset), .load_old_rt(load_old_rt),
      .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest),
      .write_reg_rd(write_reg_rd), .reg_write_enable(reg_write_enable),
      .reg_write_data(reg_write_data), .stall(stall),
      .busy_valid(busy_valid), .busy_rd(busy_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Load formatting expressed as shifts and masks over the little-endian word.
   function automatic logic [31:0] fmtLoad(input logic [2:0] t, input logic [1:0] k,
                                           input logic [31:0] m, input logic [31:0] o);
      int sh;
      logic [31:0] mask;
      logic [7:0] b;
      logic [15:0] h;
      b = 8'(m >> (8 * int'(k)));
      h = 16'(m >> (16 * int'(k[1])));
      case (t)
         3'd0: return {{24{b[7]}}, b};
         3'd1: return {24'd0, b};
         3'd2: return {{16{h[15]}}, h};
         3'd3: return {16'd0, h};
         3'd5: begin
            sh = 8 * (3 - int'(k));
            mask = (32'h1 << sh) - 32'h1;
            return (m << sh) | (o & mask);
         end
         3'd6: begin
            sh = 8 * int'(k);
            mask = ~(32'hFFFF_FFFF >> sh);
            return (m >> sh) | (o & mask);
         end
         default: return m;
      endcase
   endfunction

   typedef struct {
      logic [4:0]  rd;
      logic [2:0]  ty;
      logic [1:0]  off;
      logic [31:0] old;
   } loadDesc_t;

   loadDesc_t pendQ[$];
   logic [4:0]  lastLoadRd;
   logic [4:0]  expRd;
   logic        expWe;
   logic [31:0] expData;
   loadDesc_t   d;

   // Reference model: at most one outstanding load lives in pendQ.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         pendQ.delete();
         lastLoadRd = 0;
         expRd = 0;
         expWe = 0;
         expData = 0;
      end else if (clk_enable) begin
         expWe = 0;
         if (pendQ.size() != 0) begin
            if (!mem_waitrequest) begin
               d = pendQ.pop_front();
               expRd = d.rd;
               expData = fmtLoad(d.ty, d.off, mem_readdata, d.old);
               expWe = (d.rd != 0);
               if (expWe) $display("[TB] load write r%0d = %08h", expRd, expData);
            end
         end else begin
            if (alu_valid) begin
               expRd = alu_rd;
               expData = alu_data;
               expWe = (alu_rd != 0);
               if (expWe) $display("[TB] alu write r%0d = %08h", expRd, expData);
            end
            if (load_issue) begin
               d.rd = load_rd;
               d.ty = load_type;
               d.off = load_offset;
               d.old = load_old_rt;
               pendQ.push_back(d);
               lastLoadRd = load_rd;
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %08h, expected %08h at %0t", name, got, exp, $time);
      end
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("m_we", 32'(reg_write_enable), 32'(expWe));
         checkOutput("m_rd", 32'(write_reg_rd), 32'(expRd));
         checkOutput("m_data", reg_write_data, expData);
         checkOutput("m_stall", 32'(stall), 32'(pendQ.size() != 0));
         checkOutput("m_busyv", 32'(busy_valid), 32'(pendQ.size() != 0));
         checkOutput("m_busyrd", 32'(busy_rd), 32'(lastLoadRd));
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic applyStimulus(input bit av, input logic [4:0] ard, input logic [31:0] adat,
                                input bit li, input logic [4:0] lrd, input logic [2:0] lt,
                                input logic [1:0] lo, input logic [31:0] old,
                                input logic [31:0] m, input bit wr, input bit en);
      alu_valid = av;
      alu_rd = ard;
      alu_data = adat;
      load_issue = li;
      load_rd = lrd;
      load_type = lt;
      load_offset = lo;
      load_old_rt = old;
      mem_readdata = m;
      mem_waitrequest = wr;
      clk_enable = en;
   endtask

   task automatic idle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
   endtask

   // Issue a load, wait the given cycles, complete it; returns after the write is visible.
   task automatic doLoad(input logic [4:0] rd, input logic [2:0] t, input logic [1:0] k,
                         input logic [31:0] old, input logic [31:0] m, input int waits);
      applyStimulus(0, 0, 0, 1, rd, t, k, old, m, 1, 1);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, m, 1, 1);
      for (int i = 0; i < waits; i++) tick();
      mem_waitrequest = 0;
      tick();
      idle();
   endtask

   initial begin
      reset = 0;
      idle();
      tick();
      tick();
      checkOutput("rst_we", 32'(reg_write_enable), 0);
      checkOutput("rst_rd", 32'(write_reg_rd), 0);
      checkOutput("rst_data", reg_write_data, 0);
      checkOutput("rst_busyrd", 32'(busy_rd), 0);
      checkOutput("rst_stall", 32'(stall), 0);
      reset = 1;
      checkEn = 1;
      tick();

      // ALU path
      applyStimulus(1, 5'd3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 1, 1);
      tick();
      idle();
      checkOutput("alu_we", 32'(reg_write_enable), 1);
      checkOutput("alu_rd", 32'(write_reg_rd), 3);
      checkOutput("alu_data", reg_write_data, 32'hDEADBEEF);
      tick();
      checkOutput("alu_we_fall", 32'(reg_write_enable), 0);

      // LB with three wait cycles
      applyStimulus(0, 0, 0, 1, 5'd8, 3'd0, 2'd2, 0, 32'h12F45678, 1, 1);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'h12F45678, 1, 1);
      for (int i = 0; i < 3; i++) begin
         checkOutput("lb_stall", 32'(stall), 1);
         checkOutput("lb_busyv", 32'(busy_valid), 1);
         checkOutput("lb_busyrd", 32'(busy_rd), 8);
         tick();
      end
      mem_waitrequest = 0;
      tick();
      idle();
      checkOutput("lb_we", 32'(reg_write_enable), 1);
      checkOutput("lb_rd", 32'(write_reg_rd), 8);
      checkOutput("lb_data", reg_write_data, 32'hFFFFFFF4);
      checkOutput("lb_stall_low", 32'(stall), 0);

      doLoad(5'd9, 3'd5, 2'd1, 32'hAABBCCDD, 32'h11223344, 1);
      checkOutput("lwl_k1", reg_write_data, 32'h3344CCDD);
      doLoad(5'd10, 3'd6, 2'd2, 32'hAABBCCDD, 32'h11223344, 0);
      checkOutput("lwr_k2", reg_write_data, 32'hAABB1122);
      doLoad(5'd11, 3'd3, 2'd2, 32'hAABBCCDD, 32'h11223344, 2);
      checkOutput("lhu_k2", reg_write_data, 32'h00001122);

      // ALU held during WAIT_MEM is ignored, including on the completion cycle
      applyStimulus(0, 0, 0, 1, 5'd12, 3'd4, 2'd0, 0, 32'hCAFEF00D, 1, 1);
      tick();
      applyStimulus(1, 5'd5, 32'h55555555, 0, 0, 0, 0, 0, 32'hCAFEF00D, 1, 1);
      for (int i = 0; i < 2; i++) begin
         tick();
         checkOutput("conf_no_alu", 32'(reg_write_enable), 0);
      end
      mem_waitrequest = 0;
      tick();
      checkOutput("conf_rd", 32'(write_reg_rd), 12);
      checkOutput("conf_data", reg_write_data, 32'hCAFEF00D);
      idle();
      tick();

      // Destination $0
      applyStimulus(1, 5'd0, 32'h12345678, 0, 0, 0, 0, 0, 0, 1, 1);
      tick();
      idle();
      checkOutput("r0_we", 32'(reg_write_enable), 0);
      checkOutput("r0_data", reg_write_data, 32'h12345678);

      // Enable freeze during WAIT_MEM with memory ready
      applyStimulus(0, 0, 0, 1, 5'd13, 3'd4, 2'd0, 0, 32'h0BADC0DE, 1, 1);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'h0BADC0DE, 0, 0);
      for (int i = 0; i < 2; i++) begin
         tick();
         checkOutput("frz_stall", 32'(stall), 1);
         checkOutput("frz_we", 32'(reg_write_enable), 0);
      end
      clk_enable = 1;
      tick();
      idle();
      checkOutput("frz_done_we", 32'(reg_write_enable), 1);
      checkOutput("frz_done_data", reg_write_data, 32'h0BADC0DE);

      // Reset mid-WAIT_MEM
      applyStimulus(0, 0, 0, 1, 5'd14, 3'd4, 2'd0, 0, 32'h77777777, 1, 1);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'h77777777, 1, 1);
      tick();
      reset = 0;
      #1;
      checkOutput("mrst_stall", 32'(stall), 0);
      checkOutput("mrst_busyrd", 32'(busy_rd), 0);
      checkOutput("mrst_rd", 32'(write_reg_rd), 0);
      checkOutput("mrst_data", reg_write_data, 0);
      tick();
      reset = 1;
      mem_waitrequest = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("mrst_no_write", 32'(reg_write_enable), 0);
      end

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         applyStimulus(1'($urandom_range(0, 1)),
                       ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom),
                       $urandom,
                       ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom),
                       3'($urandom), 2'($urandom), $urandom, $urandom,
                       ($urandom_range(0, 2) != 0),
                       ($urandom_range(0, 7) != 0));
         tick();
      end
      idle();
      tick();

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Initiator for the register file write port: drives write_reg_rd, reg_write_enable and reg_write_data.
- Merges two result sources into the single write port:
  - single-cycle ALU results;
  - multi-cycle memory loads that wait on mem_waitrequest.
- Formats load data (byte/half sign/zero extension, LWL/LWR merge).
- Raises stall and exposes the pending load destination for hazard detection in the control unit.

Parameters:
- DATA_W, 32, datapath and register width.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- clk_enable  in  1  global advance enable; all state frozen when 0
- alu_valid  in  1  ALU result present this cycle
- alu_rd  in  REG_AW  ALU destination register
- alu_data  in  DATA_W  ALU result
- load_issue  in  1  load instruction issued; capture its descriptors
- load_rd  in  REG_AW  load destination register
- load_type  in  3  0=LB 1=LBU 2=LH 3=LHU 4=LW 5=LWL 6=LWR; 7 reserved (treated as LW)
- load_offset  in  2  effective address [1:0]
- load_old_rt  in  DATA_W  current rt value (used by LWL/LWR merge)
- mem_readdata  in  DATA_W  memory read data
- mem_waitrequest  in  1  memory not ready
- write_reg_rd  out  REG_AW  register file write address
- reg_write_enable  out  1  register file write strobe
- reg_write_data  out  DATA_W  register file write data
- stall  out  1  pipeline must hold; ALU results not accepted
- busy_valid  out  1  a load is outstanding
- busy_rd  out  REG_AW  destination of the outstanding load

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - write_reg_rd, reg_write_enable, reg_write_data, busy_rd all 0.
  - Captured load descriptors cleared.
  - Reset mid-load discards the pending load; no write is issued.
- clk_enable=0: state, captured descriptors and all registered outputs hold their values.
- Registered write-port outputs: a source accepted at edge N produces the write on cycles N..N+1. reg_write_enable falls the following cycle unless a new write is accepted.
- Destination $0: reg_write_enable is forced to 0 for rd==0. Data and address still update; state advances normally.
- stall = (state==WAIT_MEM) and is combinational from state.
- busy_valid = stall.
- busy_rd = captured load_rd.
- States:
  - IDLE:
    - alu_valid=1: write {alu_rd, alu_data}.
    - load_issue=1: capture rd/type/offset/old_rt, go to WAIT_MEM.
    - Both asserted in the same cycle: both honoured (ALU write plus load capture).
  - WAIT_MEM:
    - alu_valid and load_issue are ignored.
    - mem_waitrequest=1: remain in WAIT_MEM.
    - mem_waitrequest=0: write {captured rd, formatted data}, go to IDLE.
    - ALU input in the completion cycle is still ignored, because stall is high.
- Load formatting (little-endian, m=mem_readdata, o=old_rt, k=load_offset):
  - LB/LBU: byte m[8k+7:8k], sign- or zero-extended.
  - LH/LHU: half m[16*k[1]+15:16*k[1]], sign- or zero-extended. k[0] is ignored.
  - LW: m.
  - LWL:
    - k=0: {m[7:0], o[23:0]}
    - k=1: {m[15:0], o[15:0]}
    - k=2: {m[23:0], o[7:0]}
    - k=3: m
  - LWR:
    - k=0: m
    - k=1: {o[31:24], m[31:8]}
    - k=2: {o[31:16], m[31:16]}
    - k=3: {o[31:8], m[31:24]}
- Each accepted write is also reported with $display of the register number and data.

Test Plan:
- ALU path: alu_valid=1, alu_rd=3, alu_data=0xDEADBEEF in IDLE -> next cycle reg_write_enable=1, write_reg_rd=3, data=0xDEADBEEF; the cycle after, reg_write_enable=0.
- Load with wait: LB, rd=8, offset=2, waitrequest high for 3 cycles, mem_readdata=0x12F45678 -> stall and busy_valid high with busy_rd=8 throughout; after waitrequest drops, write rd=8, data=0xFFFFFFF4; stall low.
- LWL/LWR merge: old_rt=0xAABBCCDD, m=0x11223344:
  - LWL k=1 -> 0x3344CCDD
  - LWR k=2 -> 0xAABB1122
  - LHU k=2 -> 0x00001122
- Conflict and $0: alu_valid held during WAIT_MEM -> no ALU write while stall is high. alu_rd=0 -> reg_write_enable stays 0.
- Enable freeze and reset: clk_enable=0 during WAIT_MEM with waitrequest=0 -> no completion and no state change. Asserting reset mid-WAIT_MEM -> all outputs 0 immediately and no later write appears.
